// File: rtl/alarm_controller.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_controller
//  Purpose  : Vehicle anti-theft alarm core. Holds the armed/disarmed state,
//             detects intrusion (driver door, passenger door, ignition), runs
//             the entry-delay countdown and drives the siren and status LED.
//             Contains its own one-second prescaler and countdown counter.
//  Ports    : clock       - system clock, rising edge
//             reset       - synchronous, active-low reset
//             armar       - one-cycle arm request from the arming stage
//             door_driver - 1 = driver door open
//             door_pass   - 1 = passenger door open
//             ignicao     - 1 = ignition key on (disarm / intrusion source)
//             siren       - 1 = siren sounding
//             status_led  - dashboard indicator
//             armed       - 1 = any state other than DISARMED
//             state       - current state code
//  Revision : 1.0 - initial release
// ============================================================================
module alarm_controller #(
  parameter int CLK_PER_SEC = 1,   // clock cycles per one-second tick (>=1)
  parameter int T_DRIVER    = 6,   // entry delay after driver/ignition intrusion
  parameter int T_PASSENGER = 10,  // entry delay after passenger intrusion
  parameter int T_ALARM_ON  = 8,   // siren time after all doors close
  parameter int CW          = 4    // countdown counter width
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       armar,
  input  logic       door_driver,
  input  logic       door_pass,
  input  logic       ignicao,
  output logic       siren,
  output logic       status_led,
  output logic       armed,
  output logic [1:0] state
);

  // Prescaler width; a 1-bit register is kept even when CLK_PER_SEC==1 so the
  // counter stays legal (it then sits at 0 and tick is high every cycle).
  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_PER_SEC - 1);
  localparam logic [CW-1:0] CNT_DRIVER = CW'(T_DRIVER);
  localparam logic [CW-1:0] CNT_PASS   = CW'(T_PASSENGER);
  localparam logic [CW-1:0] CNT_ALARM  = CW'(T_ALARM_ON);

  typedef enum logic [1:0] {
    DISARMED  = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2,
    ALARM     = 2'd3
  } state_t;

  state_t          cur_state;
  logic [PW-1:0]   presc;
  logic [CW-1:0]   cnt;
  logic            led;
  logic            tick;

  // One-cycle pulse once per second; the prescaler free-runs and is never
  // realigned to state changes, so delays carry up to one tick of jitter.
  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge clock) begin
    if (!reset) begin
      cur_state <= DISARMED;
      presc     <= '0;
      cnt       <= '0;
      led       <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;

      case (cur_state)
        DISARMED: begin
          led <= 1'b0;
          // A key in the ignition vetoes arming.
          if (armar && !ignicao) begin
            cur_state <= ARMED;
          end
        end

        ARMED: begin
          // Driver side wins when both doors open together (shorter delay).
          if (door_driver || ignicao) begin
            cur_state <= TRIGGERED;
            cnt       <= CNT_DRIVER;
            led       <= 1'b1;
          end else if (door_pass) begin
            cur_state <= TRIGGERED;
            cnt       <= CNT_PASS;
            led       <= 1'b1;
          end else if (tick) begin
            led <= ~led;
          end
        end

        TRIGGERED: begin
          led <= 1'b1;
          // A valid key beats an expiring counter in the same cycle.
          if (ignicao) begin
            cur_state <= DISARMED;
            led       <= 1'b0;
          end else if (cnt == '0) begin
            cur_state <= ALARM;
            cnt       <= CNT_ALARM;
          end else if (tick) begin
            cnt <= cnt - 1'b1;
          end
        end

        ALARM: begin
          led <= 1'b1;
          if (ignicao) begin
            cur_state <= DISARMED;
            led       <= 1'b0;
          end else if (door_driver || door_pass) begin
            // Any open door keeps the siren timer full, so re-arming with a
            // door still open cannot happen.
            cnt <= CNT_ALARM;
          end else if (cnt == '0) begin
            cur_state <= ARMED;
            led       <= 1'b0;
          end else if (tick) begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          cur_state <= DISARMED;
          led       <= 1'b0;
        end
      endcase
    end
  end

  // Moore outputs decoded from the state register.
  assign siren      = (cur_state == ALARM);
  assign armed      = (cur_state != DISARMED);
  assign state      = cur_state;
  assign status_led = led;

endmodule
`default_nettype wire
